// File: rtl/ram_dp_sr_sw_be.sv
// rtl/ram_dp_sr_sw_be.sv - dual-port RAM, sync read, byte-enabled write, zero-fill sweep
module ram_dp_sr_sw_be #(
    parameter  int DATA_WIDTH = 32,
    parameter  int BYTE_WIDTH = 8,
    parameter  int ADDR_WIDTH = 8,
    parameter  int RAM_DEPTH  = 1 << ADDR_WIDTH,
    localparam int NUM_BYTES  = DATA_WIDTH / BYTE_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    output logic                  busy,
    input  logic                  cs_0,
    input  logic                  we_0,
    input  logic [NUM_BYTES-1:0]  be_0,
    input  logic [ADDR_WIDTH-1:0] address_0,
    input  logic [DATA_WIDTH-1:0] data_in_0,
    output logic [DATA_WIDTH-1:0] data_out_0,
    output logic                  valid_0,
    input  logic                  cs_1,
    input  logic                  we_1,
    input  logic [NUM_BYTES-1:0]  be_1,
    input  logic [ADDR_WIDTH-1:0] address_1,
    input  logic [DATA_WIDTH-1:0] data_in_1,
    output logic [DATA_WIDTH-1:0] data_out_1,
    output logic                  valid_1
);

    typedef enum logic {ST_CLEAR, ST_READY} state_e;

    localparam logic [ADDR_WIDTH:0]   DEPTH_W  = RAM_DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(RAM_DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_ptr_q, clr_ptr_d;
    logic [DATA_WIDTH-1:0] data_out_0_q, data_out_1_q;
    logic                  valid_0_q, valid_1_q;

    logic ready, in_range_0, in_range_1, rd_0, rd_1, wr_0, wr_1;

    assign ready      = (state_q == ST_READY);
    assign in_range_0 = ({1'b0, address_0} < DEPTH_W);
    assign in_range_1 = ({1'b0, address_1} < DEPTH_W);
    assign rd_0       = ready && cs_0 && !we_0;
    assign rd_1       = ready && cs_1 && !we_1;
    assign wr_0       = ready && cs_0 && we_0 && in_range_0;
    assign wr_1       = ready && cs_1 && we_1 && in_range_1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_CLEAR;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        case (state_q)
            ST_CLEAR: begin
                if (clear) begin
                    clr_ptr_d = '0;
                end else if (clr_ptr_q == LAST_PTR) begin
                    state_d   = ST_READY;
                    clr_ptr_d = '0;
                end else begin
                    clr_ptr_d = clr_ptr_q + 1'b1;
                end
            end
            ST_READY: begin
                if (clear) begin
                    state_d   = ST_CLEAR;
                    clr_ptr_d = '0;
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    // Port 0 lanes are written last so they win a same-address collision.
    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            mem[clr_ptr_q] <= '0;
        end else begin
            for (int k = 0; k < NUM_BYTES; k++) begin
                if (wr_1 && be_1[k])
                    mem[address_1][k*BYTE_WIDTH +: BYTE_WIDTH] <= data_in_1[k*BYTE_WIDTH +: BYTE_WIDTH];
            end
            for (int k = 0; k < NUM_BYTES; k++) begin
                if (wr_0 && be_0[k])
                    mem[address_0][k*BYTE_WIDTH +: BYTE_WIDTH] <= data_in_0[k*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    // Reads sample the array before this edge's writes land: read-first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out_0_q <= '0;
            data_out_1_q <= '0;
            valid_0_q    <= 1'b0;
            valid_1_q    <= 1'b0;
        end else begin
            valid_0_q <= rd_0;
            valid_1_q <= rd_1;
            if (rd_0) data_out_0_q <= in_range_0 ? mem[address_0] : '0;
            if (rd_1) data_out_1_q <= in_range_1 ? mem[address_1] : '0;
        end
    end

    assign busy       = (state_q == ST_CLEAR);
    assign data_out_0 = data_out_0_q;
    assign data_out_1 = data_out_1_q;
    assign valid_0    = valid_0_q;
    assign valid_1    = valid_1_q;

endmodule

// File: tb/tb_ram_dp_sr_sw_be.sv
// tb/tb_ram_dp_sr_sw_be.sv - directed and randomized checks of ram_dp_sr_sw_be
module tb_ram_dp_sr_sw_be;

    logic        clk = 1'b0;
    logic        reset, clear, busy;
    logic        cs0, we0, cs1, we1, v0, v1;
    logic [3:0]  be0, be1, a0, a1;
    logic [31:0] di0, di1, do0, do1;

    logic        b_cs0, b_we0, b_busy, b_v0, b_v1;
    logic [3:0]  b_be0, b_a0;
    logic [31:0] b_di0, b_do0, b_do1;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] m [16];
    logic [31:0] ed0, ed1;
    logic        er0, er1;

    always #5 clk = ~clk;

    ram_dp_sr_sw_be #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(4), .RAM_DEPTH(16)) dut (
        .clk(clk), .reset(reset), .clear(clear), .busy(busy),
        .cs_0(cs0), .we_0(we0), .be_0(be0), .address_0(a0), .data_in_0(di0),
        .data_out_0(do0), .valid_0(v0),
        .cs_1(cs1), .we_1(we1), .be_1(be1), .address_1(a1), .data_in_1(di1),
        .data_out_1(do1), .valid_1(v1)
    );

    ram_dp_sr_sw_be #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(4), .RAM_DEPTH(12)) dut_b (
        .clk(clk), .reset(reset), .clear(1'b0), .busy(b_busy),
        .cs_0(b_cs0), .we_0(b_we0), .be_0(b_be0), .address_0(b_a0), .data_in_0(b_di0),
        .data_out_0(b_do0), .valid_0(b_v0),
        .cs_1(1'b0), .we_1(1'b0), .be_1(4'h0), .address_1(4'h0), .data_in_1(32'h0),
        .data_out_1(b_do1), .valid_1(b_v1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cs0 = 0; we0 = 0; be0 = 0; a0 = 0; di0 = 0;
        cs1 = 0; we1 = 0; be1 = 0; a1 = 0; di1 = 0;
        b_cs0 = 0; b_we0 = 0; b_be0 = 0; b_a0 = 0; b_di0 = 0;
        clear = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++)
            if (be[k]) r[k*8 +: 8] = nw[k*8 +: 8];
        return r;
    endfunction

    initial begin
        reset = 1'b1;
        idle();
        step(); step();
        chk("rst_busy", {31'b0, busy}, 32'd1);
        chk("rst_do0", do0, 32'h0);
        chk("rst_v0", {31'b0, v0}, 32'd0);
        chk("rst_do1", do1, 32'h0);
        chk("rst_v1", {31'b0, v1}, 32'd0);

        // Sweep after reset release: 16 edges for A, 12 edges for B
        reset = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            step();
            chk("sweep_busy", {31'b0, busy}, (i < 16) ? 32'd1 : 32'd0);
            chk("sweep_busy_b", {31'b0, b_busy}, (i < 12) ? 32'd1 : 32'd0);
        end
        for (int a = 0; a < 16; a++) begin
            cs1 = 1; we1 = 0; a1 = 4'(a);
            step();
            chk("zero_rd_v", {31'b0, v1}, 32'd1);
            chk("zero_rd_d", do1, 32'h0);
        end
        idle();

        // Byte-enable merge
        cs0 = 1; we0 = 1; be0 = 4'b1111; a0 = 3; di0 = 32'hAABBCCDD;
        step();
        chk("wr_no_valid", {31'b0, v0}, 32'd0);
        chk("wr_no_dout", do0, 32'h0);
        di0 = 32'h11223344; be0 = 4'b0101;
        step();
        we0 = 0;
        step();
        chk("be_merge", do0, 32'hAA22CC44);
        chk("be_merge_v", {31'b0, v0}, 32'd1);
        idle();
        step();
        chk("idle_v", {31'b0, v0}, 32'd0);
        chk("idle_hold", do0, 32'hAA22CC44);

        // Dual-port collision
        cs0 = 1; we0 = 1; be0 = 4'b0011; a0 = 5; di0 = 32'h000000FF;
        cs1 = 1; we1 = 1; be1 = 4'b1110; a1 = 5; di1 = 32'h12345678;
        step();
        idle();
        cs0 = 1; a0 = 5;
        step();
        chk("collision", do0, 32'h123400FF);

        // Read-first, then a zero byte-enable write
        idle();
        cs0 = 1; we0 = 1; be0 = 4'hF; a0 = 7; di0 = 32'h5A5A5A5A;
        step();
        di0 = 32'hDEADBEEF;
        cs1 = 1; we1 = 0; a1 = 7;
        step();
        chk("read_first", do1, 32'h5A5A5A5A);
        chk("read_first_v", {31'b0, v1}, 32'd1);
        idle();
        cs0 = 1; we0 = 1; be0 = 4'h0; a0 = 7; di0 = 32'h0;
        cs1 = 1; a1 = 7;
        step();
        chk("after_write", do1, 32'hDEADBEEF);
        idle();
        cs1 = 1; a1 = 7;
        step();
        chk("be_zero", do1, 32'hDEADBEEF);

        // Clear request drops accesses during the sweep
        idle();
        clear = 1;
        step();
        clear = 0;
        chk("clr_busy", {31'b0, busy}, 32'd1);
        cs0 = 1; we0 = 1; be0 = 4'hF; a0 = 2; di0 = 32'hFFFFFFFF;
        cs1 = 1; we1 = 0; a1 = 2;
        for (int i = 1; i <= 16; i++) begin
            step();
            if (i == 1) begin
                chk("clr_drop_v1", {31'b0, v1}, 32'd0);
                chk("clr_hold_do1", do1, 32'hDEADBEEF);
                idle();
            end
            chk("clr_busy_len", {31'b0, busy}, (i < 16) ? 32'd1 : 32'd0);
        end
        cs1 = 1; a1 = 2; cs0 = 1; a0 = 7;
        step();
        chk("clr_addr2", do1, 32'h0);
        chk("clr_addr2_v", {31'b0, v1}, 32'd1);
        chk("clr_addr7", do0, 32'h0);

        // Reset in the middle of a sweep
        idle();
        cs0 = 1; we0 = 1; be0 = 4'hF; a0 = 3; di0 = 32'hCAFEF00D;
        step();
        idle();
        cs1 = 1; a1 = 3;
        step();
        chk("pre_rst_rd", do1, 32'hCAFEF00D);
        idle();
        clear = 1;
        step();
        clear = 0;
        for (int i = 0; i < 5; i++) step();
        reset = 1;
        #1;
        chk("mid_rst_do1", do1, 32'h0);
        chk("mid_rst_v1", {31'b0, v1}, 32'd0);
        chk("mid_rst_busy", {31'b0, busy}, 32'd1);
        step();
        step();
        chk("rst_held_busy", {31'b0, busy}, 32'd1);
        reset = 0;
        for (int i = 1; i <= 16; i++) begin
            step();
            chk("resweep_busy", {31'b0, busy}, (i < 16) ? 32'd1 : 32'd0);
        end

        // Out-of-range on the 12-word instance
        b_cs0 = 1; b_we0 = 1; b_be0 = 4'hF; b_a0 = 14; b_di0 = 32'h77777777;
        step();
        b_a0 = 11; b_di0 = 32'h13572468;
        step();
        b_we0 = 0; b_a0 = 14;
        step();
        chk("oor_rd", b_do0, 32'h0);
        chk("oor_rd_v", {31'b0, b_v0}, 32'd1);
        b_a0 = 6;
        step();
        chk("oor_alias", b_do0, 32'h0);
        b_a0 = 11;
        step();
        chk("last_word", b_do0, 32'h13572468);
        idle();

        // Randomized traffic against the array model
        for (int i = 0; i < 16; i++) m[i] = 32'h0;
        ed0 = 32'h0;
        ed1 = 32'h0;
        for (int n = 0; n < 400; n++) begin
            cs0 = ($urandom_range(0, 3) != 0);
            we0 = $urandom_range(0, 1);
            be0 = 4'($urandom);
            a0  = 4'($urandom);
            di0 = $urandom;
            cs1 = ($urandom_range(0, 3) != 0);
            we1 = $urandom_range(0, 1);
            be1 = 4'($urandom);
            a1  = ($urandom_range(0, 2) == 0) ? a0 : 4'($urandom);
            di1 = $urandom;
            er0 = cs0 && !we0;
            er1 = cs1 && !we1;
            if (er0) ed0 = m[a0];
            if (er1) ed1 = m[a1];
            if (cs1 && we1) m[a1] = merge(m[a1], di1, be1);
            if (cs0 && we0) m[a0] = merge(m[a0], di0, be0);
            step();
            chk("rnd_do0", do0, ed0);
            chk("rnd_v0", {31'b0, v0}, {31'b0, er0});
            chk("rnd_do1", do1, ed1);
            chk("rnd_v1", {31'b0, v1}, {31'b0, er1});
        end
        idle();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
